// File: rtl/msg_loc_queue.sv
// Pairs message start/end events into (start, end, length) descriptors and
// queues them in a first-word fall-through circular FIFO for the field extractor.
module msg_loc_queue #(
    parameter int ADDR_WIDTH = 5,
    parameter int DEPTH      = 8,
    parameter int CNT_WIDTH  = $clog2(DEPTH) + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_message_i,
    input  logic [ADDR_WIDTH-1:0] start_addr_i,
    input  logic                  end_message_i,
    input  logic [ADDR_WIDTH-1:0] end_addr_i,
    output logic                  rd_valid_o,
    input  logic                  rd_ready_i,
    output logic [ADDR_WIDTH-1:0] rd_start_o,
    output logic [ADDR_WIDTH-1:0] rd_end_o,
    output logic [ADDR_WIDTH:0]   rd_len_o,
    output logic [CNT_WIDTH-1:0]  count_o,
    output logic                  full_o,
    output logic                  empty_o,
    output logic                  open_o,
    output logic                  drop_o,
    output logic                  abort_o,
    output logic                  orphan_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [CNT_WIDTH-1:0] FULL_CNT = CNT_WIDTH'(DEPTH);

    typedef enum logic {IDLE = 1'b0, OPEN = 1'b1} state_t;

    state_t                state, next_state;
    logic [ADDR_WIDTH-1:0] start_q, next_start;

    logic                  commit;
    logic [ADDR_WIDTH-1:0] commit_start;
    logic [ADDR_WIDTH-1:0] commit_diff;
    logic [ADDR_WIDTH:0]   commit_len;
    logic                  abort_next, orphan_next, drop_next;
    logic                  pop, push;

    logic [ADDR_WIDTH-1:0] mem_start [DEPTH];
    logic [ADDR_WIDTH-1:0] mem_end   [DEPTH];
    logic [ADDR_WIDTH:0]   mem_len   [DEPTH];
    logic [PTR_W-1:0]      wr_ptr, rd_ptr;
    logic [CNT_WIDTH-1:0]  count_q;

    // Event pairing: a simultaneous start+end always closes the current
    // message (or a zero-gap one when idle) before any new start is latched.
    always_comb begin
        next_state   = state;
        next_start   = start_q;
        commit       = 1'b0;
        commit_start = start_q;
        abort_next   = 1'b0;
        orphan_next  = 1'b0;
        case (state)
            IDLE: begin
                if (start_message_i && end_message_i) begin
                    commit       = 1'b1;
                    commit_start = start_addr_i;
                end else if (start_message_i) begin
                    next_start = start_addr_i;
                    next_state = OPEN;
                end else if (end_message_i) begin
                    orphan_next = 1'b1;
                end
            end
            OPEN: begin
                if (start_message_i && end_message_i) begin
                    commit     = 1'b1;
                    next_start = start_addr_i;
                end else if (end_message_i) begin
                    commit     = 1'b1;
                    next_state = IDLE;
                end else if (start_message_i) begin
                    abort_next = 1'b1;
                    next_start = start_addr_i;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Modular subtraction handles messages that wrap around the byte ring.
    assign commit_diff = end_addr_i - commit_start;
    assign commit_len  = {1'b0, commit_diff} + (ADDR_WIDTH + 1)'(1);

    assign pop       = rd_valid_o && rd_ready_i;
    assign push      = commit && (!full_o || pop);
    assign drop_next = commit && !push;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            start_q  <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count_q  <= '0;
            drop_o   <= 1'b0;
            abort_o  <= 1'b0;
            orphan_o <= 1'b0;
        end else begin
            state    <= next_state;
            start_q  <= next_start;
            drop_o   <= drop_next;
            abort_o  <= abort_next;
            orphan_o <= orphan_next;
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            if (push && !pop)      count_q <= count_q + CNT_WIDTH'(1);
            else if (pop && !push) count_q <= count_q - CNT_WIDTH'(1);
        end
    end

    // Storage needs no reset: the pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_start[wr_ptr] <= commit_start;
            mem_end[wr_ptr]   <= end_addr_i;
            mem_len[wr_ptr]   <= commit_len;
        end
    end

    assign count_o    = count_q;
    assign full_o     = (count_q == FULL_CNT);
    assign empty_o    = (count_q == '0);
    assign rd_valid_o = !empty_o;
    assign open_o     = (state == OPEN);
    assign rd_start_o = mem_start[rd_ptr];
    assign rd_end_o   = mem_end[rd_ptr];
    assign rd_len_o   = mem_len[rd_ptr];

endmodule
